// File: rtl/left_shift_sequencer_if.sv
// Handshake and data bundle for left_shift_sequencer: start/in/amount/mode in,
// out/busy/done/ovf back. The shifter takes the slave modport.
interface left_shift_sequencer_if #(
    parameter int width = 16
);
    localparam int SW = $clog2(width) + 1;

    logic             start;
    logic [width-1:0] in;
    logic [SW-1:0]    amount;
    logic             mode;
    logic [width-1:0] out;
    logic             busy;
    logic             done;
    logic             ovf;

    modport master (
        output start, in, amount, mode,
        input  out, busy, done, ovf
    );

    modport slave (
        input  start, in, amount, mode,
        output out, busy, done, ovf
    );
endinterface

// File: rtl/left_shift_sequencer.sv
// Multi-cycle left shifter: one bit position per clock, logical (zero fill) or rotate.
// Define LSHIFT_OVF_EN to build the sticky overflow flag; otherwise ovf is tied low.
module left_shift_sequencer #(
    parameter int width = 16
) (
    input  logic                 clk,
    input  logic                 rst_n,
    left_shift_sequencer_if.slave bus
);
    localparam int SW = $clog2(width) + 1;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        DONE
    } state_e;

    state_e           state_q, state_d;
    logic [width-1:0] out_q, out_d;
    logic [SW-1:0]    cnt_q, cnt_d;
    logic             mode_q, mode_d;
    logic [SW-1:0]    amt_clamped;
    logic             accept;

    // start is only honoured between operations; SHIFT ignores it entirely
    assign accept      = bus.start && (state_q != SHIFT);
    assign amt_clamped = (bus.amount > SW'(width)) ? SW'(width) : bus.amount;

    always_comb begin
        state_d = state_q;
        out_d   = out_q;
        cnt_d   = cnt_q;
        mode_d  = mode_q;
        case (state_q)
            SHIFT: begin
                out_d = {out_q[width-2:0], mode_q & out_q[width-1]};
                cnt_d = cnt_q - SW'(1);
                if (cnt_q == SW'(1)) begin
                    state_d = DONE;
                end
            end
            default: begin
                state_d = IDLE;
                if (accept) begin
                    out_d   = bus.in;
                    mode_d  = bus.mode;
                    cnt_d   = amt_clamped;
                    state_d = (amt_clamped != '0) ? SHIFT : DONE;
                end
            end
        endcase
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state_q <= IDLE;
            out_q   <= '0;
            cnt_q   <= '0;
            mode_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            out_q   <= out_d;
            cnt_q   <= cnt_d;
            mode_q  <= mode_d;
        end
    end

`ifdef LSHIFT_OVF_EN
    logic ovf_q, ovf_d;

    // sticky: any logical-mode shift that drops a 1 off the MSB sets it until the next accept
    always_comb begin
        ovf_d = ovf_q;
        if (accept) begin
            ovf_d = 1'b0;
        end else if ((state_q == SHIFT) && !mode_q && out_q[width-1]) begin
            ovf_d = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            ovf_q <= 1'b0;
        end else begin
            ovf_q <= ovf_d;
        end
    end

    assign bus.ovf = ovf_q;
`else
    assign bus.ovf = 1'b0;
`endif

    assign bus.out  = out_q;
    assign bus.busy = (state_q == SHIFT);
    assign bus.done = (state_q == DONE);
endmodule

// File: tb/tb_left_shift_sequencer.sv
// Self-checking bench for left_shift_sequencer (width=16): directed scenarios plus
// randomized operations compared against an arithmetic reference model.
module tb_left_shift_sequencer;
    localparam int W = 16;

    logic clk = 1'b0;
    logic rst_n;
    always #5 clk = ~clk;

    left_shift_sequencer_if #(.width(W)) bus_if ();
    left_shift_sequencer #(.width(W)) dut (
        .clk  (clk),
        .rst_n(rst_n),
        .bus  (bus_if)
    );

    int checks   = 0;
    int failures = 0;

    function automatic int clampk(input int a);
        return (a > W) ? W : a;
    endfunction

    // Result of shifting v left by min(a,W) positions, computed in one step
    function automatic logic [15:0] model_out(input logic [15:0] v, input int a, input bit m);
        int k;
        int unsigned x;
        k = clampk(a);
        x = {16'h0, v};
        if (m) return 16'((x << k) | (x >> (W - k)));
        return 16'(x << k);
    endfunction

    // Overflow happens when any of the top k operand bits is 1 in logical mode
    function automatic logic model_ovf(input logic [15:0] v, input int a, input bit m);
`ifdef LSHIFT_OVF_EN
        int k;
        int unsigned x;
        k = clampk(a);
        x = {16'h0, v};
        return !m && (k > 0) && ((x >> (W - k)) != 0);
`else
        return 1'b0;
`endif
    endfunction

    // Drive one accepted start; returns at the first sample after the accept edge
    task automatic start_op(input logic [15:0] v, input int a, input bit m);
        @(negedge clk);
        bus_if.in     = v;
        bus_if.amount = 5'(a);
        bus_if.mode   = m;
        bus_if.start  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start  = 1'b0;
        bus_if.in     = 16'($urandom);
        bus_if.amount = 5'($urandom);
        bus_if.mode   = 1'($urandom);
    endtask

    // Count busy cycles until done, bounded; done_idx is -1 if done never came
    task automatic observe(output int busy_cnt, output int done_idx);
        busy_cnt = 0;
        done_idx = -1;
        for (int i = 0; i < 40; i++) begin
            if (bus_if.done === 1'b1) begin
                done_idx = i;
                break;
            end
            if (bus_if.busy === 1'b1) busy_cnt++;
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset();
        rst_n         = 1'b0;
        bus_if.start  = 1'b1;
        bus_if.in     = 16'hBEEF;
        bus_if.amount = 5'd3;
        bus_if.mode   = 1'b0;
        repeat (2) @(posedge clk);
        #1;
        checks++;
        if (bus_if.out !== 16'h0) begin failures++; $display("FAIL reset_out: got %h want 0000", bus_if.out); end
        checks++;
        if ({bus_if.busy, bus_if.done, bus_if.ovf} !== 3'b000) begin
            failures++; $display("FAIL reset_flags: busy/done/ovf got %b want 000", {bus_if.busy, bus_if.done, bus_if.ovf});
        end
        @(negedge clk);
        bus_if.start = 1'b0;
        rst_n        = 1'b1;
        @(posedge clk);
        #1;
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b00) begin
            failures++; $display("FAIL reset_idle: busy/done got %b want 00", {bus_if.busy, bus_if.done});
        end
    endtask

    task automatic test_logical();
        int bc, di;
        logic [15:0] held;
        start_op(16'h00F0, 4, 1'b0);
        observe(bc, di);
        checks++;
        if (bc !== 4) begin failures++; $display("FAIL logical_busy: got %0d want 4", bc); end
        checks++;
        if (di !== 4) begin failures++; $display("FAIL logical_done_idx: got %0d want 4", di); end
        checks++;
        if (bus_if.out !== 16'h0F00) begin failures++; $display("FAIL logical_out: got %h want 0f00", bus_if.out); end
        checks++;
        if (bus_if.ovf !== 1'b0) begin failures++; $display("FAIL logical_ovf: got %b want 0", bus_if.ovf); end
        held = 16'h0F00;
        repeat (3) begin
            @(posedge clk);
            #1;
            checks++;
            if ({bus_if.busy, bus_if.done, bus_if.out} !== {2'b00, held}) begin
                failures++; $display("FAIL idle_hold: busy/done/out got %b%b %h want 00 %h", bus_if.busy, bus_if.done, bus_if.out, held);
            end
        end
    endtask

    task automatic test_rotate();
        int bc, di;
        start_op(16'h8001, 1, 1'b1);
        observe(bc, di);
        checks++;
        if (di !== 1) begin failures++; $display("FAIL rot1_done_idx: got %0d want 1", di); end
        checks++;
        if (bus_if.out !== 16'h0003) begin failures++; $display("FAIL rot1_out: got %h want 0003", bus_if.out); end
        start_op(16'hA5A5, 16, 1'b1);
        observe(bc, di);
        checks++;
        if (bc !== 16 || di !== 16) begin failures++; $display("FAIL rot16_timing: busy %0d idx %0d want 16 16", bc, di); end
        checks++;
        if (bus_if.out !== 16'hA5A5) begin failures++; $display("FAIL rot16_out: got %h want a5a5", bus_if.out); end
        checks++;
        if (bus_if.ovf !== 1'b0) begin failures++; $display("FAIL rot16_ovf: got %b want 0", bus_if.ovf); end
    endtask

    task automatic test_overflow();
        int bc, di;
        start_op(16'hC000, 1, 1'b0);
        observe(bc, di);
        checks++;
        if (bus_if.out !== 16'h8000) begin failures++; $display("FAIL ovf_out: got %h want 8000", bus_if.out); end
        checks++;
        if (bus_if.ovf !== model_ovf(16'hC000, 1, 1'b0)) begin
            failures++; $display("FAIL ovf_set: got %b want %b", bus_if.ovf, model_ovf(16'hC000, 1, 1'b0));
        end
        start_op(16'h0001, 1, 1'b0);
        checks++;
        if (bus_if.ovf !== 1'b0) begin failures++; $display("FAIL ovf_clear_on_accept: got %b want 0", bus_if.ovf); end
        observe(bc, di);
        checks++;
        if (bus_if.out !== 16'h0002 || bus_if.ovf !== 1'b0) begin
            failures++; $display("FAIL ovf_next: out %h ovf %b want 0002 0", bus_if.out, bus_if.ovf);
        end
    endtask

    task automatic test_zero_clamp();
        int bc, di;
        start_op(16'h1234, 0, 1'($urandom));
        observe(bc, di);
        checks++;
        if (bc !== 0 || di !== 0) begin failures++; $display("FAIL zero_timing: busy %0d idx %0d want 0 0", bc, di); end
        checks++;
        if (bus_if.out !== 16'h1234) begin failures++; $display("FAIL zero_out: got %h want 1234", bus_if.out); end
        start_op(16'hFFFF, 20, 1'b0);
        observe(bc, di);
        checks++;
        if (bc !== 16 || di !== 16) begin failures++; $display("FAIL clamp_timing: busy %0d idx %0d want 16 16", bc, di); end
        checks++;
        if (bus_if.out !== 16'h0000) begin failures++; $display("FAIL clamp_out: got %h want 0000", bus_if.out); end
        checks++;
        if (bus_if.ovf !== model_ovf(16'hFFFF, 20, 1'b0)) begin
            failures++; $display("FAIL clamp_ovf: got %b want %b", bus_if.ovf, model_ovf(16'hFFFF, 20, 1'b0));
        end
    endtask

    task automatic test_busy_ignore();
        int bc, di;
        logic [15:0] v;
        v = 16'hF00F;
        start_op(v, 8, 1'b0);
        repeat (2) begin @(posedge clk); #1; end
        bus_if.in     = 16'h5555;
        bus_if.amount = 5'd2;
        bus_if.mode   = 1'b1;
        bus_if.start  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        observe(bc, di);
        checks++;
        if (bc !== 5 || di !== 5) begin failures++; $display("FAIL ignore_timing: busy %0d idx %0d want 5 5", bc, di); end
        checks++;
        if (bus_if.out !== model_out(v, 8, 1'b0)) begin
            failures++; $display("FAIL ignore_out: got %h want %h", bus_if.out, model_out(v, 8, 1'b0));
        end
        checks++;
        if (bus_if.ovf !== model_ovf(v, 8, 1'b0)) begin
            failures++; $display("FAIL ignore_ovf: got %b want %b", bus_if.ovf, model_ovf(v, 8, 1'b0));
        end
    endtask

    task automatic test_back_to_back();
        int bc, di;
        logic [15:0] v1, v2;
        v1 = 16'($urandom);
        v2 = 16'($urandom);
        start_op(v1, 3, 1'b1);
        observe(bc, di);
        checks++;
        if (di !== 3 || bus_if.out !== model_out(v1, 3, 1'b1)) begin
            failures++; $display("FAIL b2b_first: idx %0d out %h want 3 %h", di, bus_if.out, model_out(v1, 3, 1'b1));
        end
        bus_if.in     = v2;
        bus_if.amount = 5'd5;
        bus_if.mode   = 1'b0;
        bus_if.start  = 1'b1;
        @(posedge clk);
        #1;
        bus_if.start = 1'b0;
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b10) begin
            failures++; $display("FAIL b2b_no_gap: busy/done got %b want 10", {bus_if.busy, bus_if.done});
        end
        observe(bc, di);
        checks++;
        if (bc !== 5 || di !== 5) begin failures++; $display("FAIL b2b_timing: busy %0d idx %0d want 5 5", bc, di); end
        checks++;
        if (bus_if.out !== model_out(v2, 5, 1'b0) || bus_if.ovf !== model_ovf(v2, 5, 1'b0)) begin
            failures++; $display("FAIL b2b_second: out %h ovf %b want %h %b", bus_if.out, bus_if.ovf,
                                 model_out(v2, 5, 1'b0), model_ovf(v2, 5, 1'b0));
        end
    endtask

    task automatic test_reset_mid();
        int bc, di;
        start_op(16'hFFFF, 10, 1'b0);
        repeat (3) begin @(posedge clk); #1; end
        @(negedge clk);
        rst_n = 1'b0;
        @(posedge clk);
        #1;
        rst_n = 1'b1;
        checks++;
        if ({bus_if.out, bus_if.busy, bus_if.done, bus_if.ovf} !== 19'h0) begin
            failures++; $display("FAIL midreset: out %h busy %b done %b ovf %b want 0000 0 0 0",
                                 bus_if.out, bus_if.busy, bus_if.done, bus_if.ovf);
        end
        @(posedge clk);
        #1;
        checks++;
        if ({bus_if.busy, bus_if.done} !== 2'b00) begin
            failures++; $display("FAIL midreset_idle: busy/done got %b want 00", {bus_if.busy, bus_if.done});
        end
        start_op(16'h0003, 2, 1'b1);
        observe(bc, di);
        checks++;
        if (di !== 2 || bus_if.out !== 16'h000C) begin
            failures++; $display("FAIL midreset_after: idx %0d out %h want 2 000c", di, bus_if.out);
        end
    endtask

    task automatic test_random();
        int bc, di, a, k;
        logic [15:0] v;
        bit m;
        for (int n = 0; n < 25; n++) begin
            v = 16'($urandom);
            a = $urandom_range(0, 20);
            m = 1'($urandom_range(0, 1));
            k = clampk(a);
            start_op(v, a, m);
            observe(bc, di);
            checks++;
            if (bc !== k || di !== k) begin
                failures++; $display("FAIL rand_timing[%0d]: busy %0d idx %0d want %0d %0d", n, bc, di, k, k);
            end
            checks++;
            if (bus_if.out !== model_out(v, a, m)) begin
                failures++; $display("FAIL rand_out[%0d]: in %h amt %0d mode %b got %h want %h",
                                     n, v, a, m, bus_if.out, model_out(v, a, m));
            end
            checks++;
            if (bus_if.ovf !== model_ovf(v, a, m)) begin
                failures++; $display("FAIL rand_ovf[%0d]: in %h amt %0d mode %b got %b want %b",
                                     n, v, a, m, bus_if.ovf, model_ovf(v, a, m));
            end
            @(posedge clk);
            #1;
            checks++;
            if (bus_if.done !== 1'b0) begin failures++; $display("FAIL rand_done_pulse[%0d]: done got %b want 0", n, bus_if.done); end
        end
    endtask

    initial begin
        test_reset();
        test_logical();
        test_rotate();
        test_overflow();
        test_zero_clamp();
        test_busy_ignore();
        test_back_to_back();
        test_reset_mid();
        test_random();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end
endmodule

// File: doc/left_shift_sequencer.md
# left_shift_sequencer

Multi-cycle left shifter that shifts one bit position per clock, N positions in total, in either logical or rotate mode. It uses a start/busy/done handshake. It is the left-direction companion to the team's right shift register. Datapath logic uses it to scale values up, or to re-align words that the right shifter moved down. An optional sticky overflow flag reports significant bits lost off the MSB.

## Interface
- `width`, default 16: data width in bits; must be ≥ 2.
- `SW`, default `$clog2(width)+1`: width of the shift-amount port (localparam, derived).

- `clk`  input  1: rising-edge clock.
- `rst_n`  input  1: synchronous reset, active-low.
- `start`  input  1: request a new operation; sampled on rising `clk`.
- `in`  input  width: operand, captured when `start` is accepted.
- `amount`  input  SW: number of positions to shift, captured when `start` is accepted.
- `mode`  input  1: 0 = logical left shift (zero fill); 1 = rotate left (MSB wraps to LSB). Captured when `start` is accepted.
- `out`  output  width: working/result register.
- `busy`  output  1: high while shifting is in progress.
- `done`  output  1: single-cycle pulse when the result is valid.
- `ovf`  output  1: sticky overflow (see Configuration).

## Operation
- FSM states: IDLE, SHIFT, DONE.
- **Reset.** `rst_n` low at a clock edge forces IDLE, `out`=0, `busy`=0, `done`=0, `ovf`=0, internal count=0, captured mode=0. This applies in any state, including mid-SHIFT; the partial result is discarded.
- **Accept.** `start` is accepted in IDLE or DONE. It is ignored in SHIFT, with no effect on `out`, the count or `mode`.
- **On accept:**
  - `out`←`in`; captured mode←`mode`; `ovf`←0.
  - count←min(`amount`, `width`). Amounts greater than `width` are clamped to `width`.
  - Next state is SHIFT if the clamped count ≠ 0, otherwise DONE.
- **SHIFT, each edge:**
  - Logical mode: `out`←{`out`[width-2:0], 1'b0}.
  - Rotate mode: `out`←{`out`[width-2:0], `out`[width-1]}.
  - count←count−1.
  - When count==1 at the edge, the next state is DONE.
- **DONE.** Lasts exactly one cycle; `out` holds. Next state is SHIFT or DONE if `start` is accepted, otherwise IDLE.
- **IDLE.** `out` holds its last value indefinitely.
- Outputs are decoded from state: `busy` = (state==SHIFT); `done` = (state==DONE).
- `in`, `amount` and `mode` may change freely after the accept edge without affecting the running operation.

## Timing
- Accept at edge T with clamped count k:
  - `busy` is high for cycles T+1 … T+k.
  - The final shift occurs at edge T+k.
  - `done` is high in the cycle after edge T+k.
  - For k=0, `done` is high in the cycle after edge T and `busy` never asserts.
- Throughput: k+1 cycles per operation. Back-to-back operation is achieved by asserting `start` during DONE.
- `out` is valid and stable whenever `done`=1 and throughout IDLE.
- Rotate by `width` returns the original operand; logical shift by `width` yields 0.

## Configuration
- Macro: `LSHIFT_OVF_EN`.
- **Defined:** in logical mode, `ovf` is set whenever a shift edge discards an `out`[width-1] equal to 1. It stays set until the next accept or reset. In rotate mode `ovf` stays 0.
- **Not defined:** `ovf` is tied to 0 and no overflow logic is synthesized. All other behaviour is identical.

## Test plan
All scenarios use `width`=16.
- **Logical shift.** `in`=16'h00F0, `amount`=4, `mode`=0 → `busy` high for 4 cycles; `done` pulses once; `out`=16'h0F00; `ovf`=0.
- **Rotate.** `in`=16'h8001, `amount`=1, `mode`=1 → `out`=16'h0003, `done` in the cycle after T+1. Then `in`=16'hA5A5, `amount`=16, `mode`=1 → `out`=16'hA5A5.
- **Overflow.** `in`=16'hC000, `amount`=1, `mode`=0 → `out`=16'h8000; `ovf`=1 with the macro defined, 0 without it. Next accept of `in`=16'h0001, `amount`=1 → `ovf` clears and `out`=16'h0002.
- **Zero and clamped amounts.** `amount`=0 with `in`=16'h1234 → `done` in the cycle after T, `busy` never high, `out`=16'h1234. `amount`=20 with `in`=16'hFFFF, `mode`=0 → 16 shift cycles, `out`=16'h0000, `ovf`=1 (macro defined).
- **Busy and back-to-back.** Pulse `start` with new operands during SHIFT → ignored; the result matches the original operation. Assert `start` during DONE → new operation accepted, with no idle cycle in between.
- **Reset mid-operation.** Drive `rst_n`=0 for one edge during SHIFT → next cycle `out`=0, `busy`=0, `done`=0, `ovf`=0, state IDLE. A subsequent operation completes normally.
